hazard_sched: RTL
=================

Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage core. Decides each cycle whether the front end advances, stalls or flushes.
- Tracks per-stage valid bits and drives the forwarding unit's USE_MEM_BACK / USE_WB_BACK enables, so bubbles never forward.
- Sequences the multi-cycle multiply/divide unit (MDU) busy window and inserts load-use stalls the forwarding network cannot cover.

Parameters:
- MDU_LAT, 4, cycles from MDU op entering EX until HI/LO are readable (>=1).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global freeze (memory wait); all pipeline registers hold.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_useRs  in  1  ID instruction reads rs in EX.
- ID_useRt  in  1  ID instruction reads rt as ALU operand in EX.
- ID_rtStoreOnly  in  1  rt read only as store data; load→store is covered by MEM-stage forwarding.
- ID_mduStart  in  1  ID instruction is a mult/div.
- ID_useHiLo  in  1  ID instruction reads HI/LO (mfhi/mflo).
- EX_rd  in  5  destination register of instruction in EX.
- EX_memToReg  in  1  EX instruction is a load.
- EX_branchTaken  in  1  branch/jump in EX resolved taken.
- front_en  out  1  PC and IF/ID register enable.
- pipe_en  out  1  ID/EX, EX/MEM, MEM/WB register enable.
- ifid_flush  out  1  clear IF/ID to bubble.
- idex_flush  out  1  clear ID/EX to bubble.
- use_mem_back  out  1  MEM-stage forwarding enable (= mem_valid).
- use_wb_back  out  1  WB-stage forwarding enable (= wb_valid).
- mdu_busy  out  1  MDU result not yet available.

Behaviour:
- Internal state:
  - Valid bits id_valid, ex_valid, mem_valid, wb_valid.
  - MDU down-counter mdu_cnt, width clog2(MDU_LAT+1).
  - FSM state RUN / MDU_WAIT.
- Reset (async, rst_n=0): all valids 0, mdu_cnt 0, state RUN. Outputs: front_en=1, pipe_en=1, flushes 0, use_* 0, mdu_busy 0.
- load_hz = id_valid & ex_valid & EX_memToReg & EX_rd!=0 & ((ID_useRs & ID_rs==EX_rd) | (ID_useRt & !ID_rtStoreOnly & ID_rt==EX_rd)).
- mdu_hz = id_valid & state==MDU_WAIT & (ID_useHiLo | ID_mduStart).
- flush = ex_valid & EX_branchTaken.
- Priority (hold > flush > stall):
  - hold=1: front_en=0, pipe_en=0, flushes 0; valids and FSM hold. mdu_cnt still decrements.
  - flush: front_en=1, pipe_en=1, ifid_flush=1, idex_flush=1. Any load_hz/mdu_hz is ignored; the ID instruction is wrong-path.
  - stall (load_hz|mdu_hz): front_en=0, pipe_en=1, idex_flush=1, ifid_flush=0.
  - Otherwise: everything enabled, no flush.
- Valid update on non-hold edges:
  - id_valid <= flush?0 : stall?id_valid : 1.
  - ex_valid <= (flush|stall)?0 : id_valid.
  - mem_valid <= ex_valid.
  - wb_valid <= mem_valid.
  - First cycle after reset id_valid=0, so no hazards are possible.
- MDU launch occurs when id_valid & ID_mduStart & !hold & !flush & !stall.
  - Launch loads mdu_cnt=MDU_LAT and sets state MDU_WAIT.
  - Launch while already in MDU_WAIT is impossible, because mdu_hz stalls it.
- In MDU_WAIT, mdu_cnt decrements every clock, including during hold. When it reaches 0, state returns to RUN. mdu_busy = (state==MDU_WAIT).
- Load-use stall lasts exactly 1 cycle. The bubble in EX clears load_hz on the next cycle; no FSM state is needed.
- Branch in EX while hold=1: flush deferred until hold drops, since the branch remains in EX.
- Reset mid-MDU: counter and state clear immediately; the next HI/LO reader is not stalled.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt[CNT_W-1:0] and perf_flush_cnt[CNT_W-1:0].
  - perf_stall_cnt increments on each non-hold cycle with stall & !flush.
  - perf_flush_cnt increments on each non-hold cycle with flush.
  - Counters wrap modulo 2^CNT_W and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then 3 independent instructions → use_mem_back first 1 at cycle 3, use_wb_back at cycle 4; front_en constantly 1.
- Load in EX with EX_rd=5, ID_rs=5, ID_useRs=1 → exactly 1 cycle front_en=0, idex_flush=1, ex_valid bubble; next cycle front_en=1.
- Same load with ID_rt=5, ID_useRt=1, ID_rtStoreOnly=1 → no stall; also EX_rd=0 with rs=0 → no stall.
- MDU_LAT=4: mult launches, mfhi follows in ID → mdu_busy high 4 cycles, front_en=0 during the busy window (apart from the launch cycle), mfhi advances the cycle mdu_busy falls.
- Load-use condition plus EX_branchTaken=1 in the same cycle → ifid_flush=idex_flush=1, front_en=1, no stall; perf_flush_cnt +1, perf_stall_cnt unchanged (HAZARD_PERF_EN).
- hold=1 for 3 cycles with a taken branch in EX → no flush and all enables 0 during hold; flush fires on the first cycle after hold=0. rst_n pulse mid-MDU → mdu_busy=0 immediately.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage core: advance/stall/flush decisions, stage valids, MDU busy window.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_sched #(
    parameter int MDU_LAT = 4
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_useRs,
    input  logic       ID_useRt,
    input  logic       ID_rtStoreOnly,
    input  logic       ID_mduStart,
    input  logic       ID_useHiLo,
    input  logic [4:0] EX_rd,
    input  logic       EX_memToReg,
    input  logic       EX_branchTaken,
    output logic       front_en,
    output logic       pipe_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       use_mem_back,
    output logic       use_wb_back,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
`endif
    output logic       mdu_busy
);
    localparam int CW = $clog2(MDU_LAT + 1);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_mdu_cnt;
    logic          r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid;
    logic          w_load_hz, w_mdu_hz, w_flush, w_stall, w_launch;

    // Store-data-only rt reads are served by MEM-stage forwarding, so they never stall.
    always_comb begin
        w_load_hz = r_id_valid & r_ex_valid & EX_memToReg & (EX_rd != 5'd0) &
                    ((ID_useRs & (ID_rs == EX_rd)) |
                     (ID_useRt & ~ID_rtStoreOnly & (ID_rt == EX_rd)));
        w_mdu_hz  = r_id_valid & (r_state == MDU_WAIT) & (ID_useHiLo | ID_mduStart);
        w_flush   = r_ex_valid & EX_branchTaken;
        w_stall   = w_load_hz | w_mdu_hz;
        w_launch  = r_id_valid & ID_mduStart & ~hold & ~w_flush & ~w_stall;
    end

    // hold > flush > stall; a wrong-path ID instruction never stalls.
    always_comb begin
        front_en   = 1'b1;
        pipe_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (hold) begin
            front_en = 1'b0;
            pipe_en  = 1'b0;
        end else if (w_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_stall) begin
            front_en   = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign use_mem_back = r_mem_valid;
    assign use_wb_back  = r_wb_valid;
    assign mdu_busy     = (r_state == MDU_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else if (!hold) begin
            r_id_valid  <= w_flush ? 1'b0 : (w_stall ? r_id_valid : 1'b1);
            r_ex_valid  <= (w_flush | w_stall) ? 1'b0 : r_id_valid;
            r_mem_valid <= r_ex_valid;
            r_wb_valid  <= r_mem_valid;
        end
    end

    // The MDU keeps computing through a memory hold, so the countdown ignores hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_mdu_cnt <= '0;
        end else if (w_launch) begin
            r_state   <= MDU_WAIT;
            r_mdu_cnt <= CW'(MDU_LAT);
        end else if (r_state == MDU_WAIT) begin
            if (r_mdu_cnt <= CW'(1)) begin
                r_mdu_cnt <= '0;
                r_state   <= RUN;
            end else begin
                r_mdu_cnt <= r_mdu_cnt - CW'(1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            if (w_stall & ~w_flush) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush)            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif
endmodule
